// File: rtl/arb_pkg.sv
// Shared types and index/saturation helpers for the dynamic-priority arbiter family.
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Saturating add, clamped to the largest w-bit unsigned value.
  function automatic int sat_add(input int a, input int b, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (a + b > lim) ? lim : a + b;
  endfunction

  // Wraps an index in [0, 2n) back into [0, n); works for any n, not just powers of two.
  function automatic int idx_wrap(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: highest eff among requesters, ties to the first index at/after rr_ptr.
// Zero latency; no flow control of its own, any_req reports whether anything competed.
module arb_pick
  import arb_pkg::*;
#(
  parameter int N  = 8,
  parameter int EW = 5,
  localparam int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [EW-1:0] eff [N],
  input  logic [GW-1:0] rr_ptr,
  output logic [GW-1:0] winner,
  output logic          any_req
);

  logic [EW-1:0] best_eff;
  int            scan_idx;

  // Scan in round-robin order; strict '>' keeps the earliest tied index.
  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    best_eff = '0;
    scan_idx = 0;
    for (int k = 0; k < N; k++) begin
      scan_idx = idx_wrap(int'(rr_ptr) + k, N);
      if (req[scan_idx] && (!any_req || eff[scan_idx] > best_eff)) begin
        any_req  = 1'b1;
        best_eff = eff[scan_idx];
        winner   = GW'(scan_idx);
      end
    end
  end

endmodule

// File: rtl/dyn_prio_arbiter.sv
// N-way arbiter: dynamic priority (prt + age), round-robin ties, optional tenure limit.
// Grant registered one cycle after an enabled IDLE decision; holder releases by dropping req, no preemption.
module dyn_prio_arbiter
  import arb_pkg::*;
#(
  parameter int N       = 8,
  parameter int PW      = 4,
  parameter int MAX_TEN = 0,
  localparam int GW     = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] prt [N],
  output logic          valid,
  output logic [GW-1:0] grant,
  output logic [N-1:0]  grant_oh
);

  localparam int EW       = PW + 1;
  localparam int TW       = (MAX_TEN > 0) ? $clog2(MAX_TEN + 1) : 1;
  localparam int TEN_LAST = (MAX_TEN > 0) ? MAX_TEN - 1 : 0;

  arb_state_t    state;
  logic [PW-1:0] age [N];
  logic [GW-1:0] rr_ptr;
  logic [TW-1:0] tenure;
  logic [EW-1:0] eff [N];
  logic [GW-1:0] pick_idx;
  logic          pick_any;
  logic          hold_req;
  logic          ten_hit;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      eff[i] = EW'(sat_add(int'(prt[i]), int'(age[i]), PW));
    end
  end

  arb_pick #(.N(N), .EW(EW)) u_pick (
    .req     (req),
    .eff     (eff),
    .rr_ptr  (rr_ptr),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  // grant_oh avoids indexing req with a grant value that may exceed N-1 for non-power-of-two N.
  assign hold_req = |(req & grant_oh);
  assign ten_hit  = (MAX_TEN != 0) && (tenure == TW'(TEN_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= 1'b0;
      grant    <= '0;
      grant_oh <= '0;
      rr_ptr   <= '0;
      tenure   <= '0;
      for (int i = 0; i < N; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) age[i] <= '0;
      end
      case (state)
        IDLE: begin
          if (en && pick_any) begin
            state    <= GRANT;
            valid    <= 1'b1;
            grant    <= pick_idx;
            grant_oh <= N'(1) << pick_idx;
            rr_ptr   <= GW'(idx_wrap(int'(pick_idx) + 1, N));
            tenure   <= '0;
            for (int i = 0; i < N; i++) begin
              if (req[i]) begin
                if (i == int'(pick_idx)) age[i] <= '0;
                else                     age[i] <= PW'(sat_add(int'(age[i]), 1, PW));
              end
            end
          end
        end
        GRANT: begin
          // en deliberately ignored here so a slowed board cannot stretch or cut a grant.
          if (!hold_req || ten_hit) begin
            state    <= IDLE;
            valid    <= 1'b0;
            grant_oh <= '0;
            tenure   <= '0;
          end else begin
            tenure <= tenure + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dyn_prio_arbiter.sv
// Directed bench for dyn_prio_arbiter: default N=8, a N=5 instance and a MAX_TEN=3 instance.
module tb_dyn_prio_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=8, unlimited tenure
  logic       en8;
  logic [7:0] req8;
  logic [3:0] prt8 [8];
  logic       valid8;
  logic [2:0] grant8;
  logic [7:0] oh8;

  // N=5
  logic       en5;
  logic [4:0] req5;
  logic [3:0] prt5 [5];
  logic       valid5;
  logic [2:0] grant5;
  logic [4:0] oh5;

  // N=8, MAX_TEN=3
  logic       ent;
  logic [7:0] reqt;
  logic [3:0] prtt [8];
  logic       validt;
  logic [2:0] grantt;
  logic [7:0] oht;

  dyn_prio_arbiter #(.N(8), .PW(4), .MAX_TEN(0)) u8 (
    .clk(clk), .rst(rst), .en(en8), .req(req8), .prt(prt8),
    .valid(valid8), .grant(grant8), .grant_oh(oh8)
  );

  dyn_prio_arbiter #(.N(5), .PW(4), .MAX_TEN(0)) u5 (
    .clk(clk), .rst(rst), .en(en5), .req(req5), .prt(prt5),
    .valid(valid5), .grant(grant5), .grant_oh(oh5)
  );

  dyn_prio_arbiter #(.N(8), .PW(4), .MAX_TEN(3)) ut (
    .clk(clk), .rst(rst), .en(ent), .req(reqt), .prt(prtt),
    .valid(validt), .grant(grantt), .grant_oh(oht)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] seq8 [8];
    logic [2:0] alt [4];
    logic       pat [8];
    logic [7:0] oh_exp;

    seq8 = '{3'd7, 3'd6, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd0};
    alt  = '{3'd1, 3'd2, 3'd1, 3'd2};
    pat  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    en8 = 1'b0; req8 = '0; en5 = 1'b0; req5 = '0; ent = 1'b0; reqt = '0;
    for (int i = 0; i < 8; i++) begin prt8[i] = '0; prtt[i] = '0; end
    for (int i = 0; i < 5; i++) prt5[i] = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("reset_valid", 32'(valid8), 32'd0);
    chk("reset_grant", 32'(grant8), 32'd0);
    chk("reset_oh",    32'(oh8),    32'd0);

    // No requests with arbitration enabled: never grants.
    en8 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_valid", 32'(valid8), 32'd0);
      chk("idle_oh",    32'(oh8),    32'd0);
    end

    // prt 7..0 = {7,6,5,5,5,5,2,0}; each winner holds 2 cycles then withdraws for good.
    prt8 = '{4'd0, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6, 4'd7};
    req8 = 8'hFF;
    for (int d = 0; d < 8; d++) begin
      tick();
      oh_exp = 8'b1 << seq8[d];
      chk("prio_valid", 32'(valid8), 32'd1);
      chk("prio_grant", 32'(grant8), 32'(seq8[d]));
      chk("prio_oh",    32'(oh8),    32'(oh_exp));
      tick();
      chk("prio_hold2", 32'(valid8), 32'd1);
      req8[seq8[d]] = 1'b0;
      tick();
      chk("prio_release", 32'(valid8), 32'd0);
    end
    tick();
    chk("prio_drained", 32'(valid8), 32'd0);

    // Equal priorities, requesters 1 and 2 each release after a single cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) prt8[i] = 4'd3;
    req8 = 8'b0000_0110;
    for (int d = 0; d < 4; d++) begin
      tick();
      chk("alt_valid", 32'(valid8), 32'd1);
      chk("alt_grant", 32'(grant8), 32'(alt[d]));
      req8[alt[d]] = 1'b0;
      tick();
      chk("alt_release", 32'(valid8), 32'd0);
      req8[alt[d]] = 1'b1;
    end

    // Reset mid-grant, then the next decision must see rr_ptr=0 and cleared ages.
    rst = 1'b1;
    req8 = '0;
    tick();
    rst = 1'b0;
    req8 = 8'b0000_0110;
    tick();
    chk("rst_pre_grant", 32'(grant8), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_valid", 32'(valid8), 32'd0);
    chk("rst_grant", 32'(grant8), 32'd0);
    chk("rst_oh",    32'(oh8),    32'd0);
    rst = 1'b0;
    req8 = 8'b0000_0101;
    tick();
    chk("rst_next_valid", 32'(valid8), 32'd1);
    chk("rst_next_grant", 32'(grant8), 32'd0);
    req8 = '0;
    tick();
    chk("rst_next_rel", 32'(valid8), 32'd0);

    // en gates decisions only.
    en8 = 1'b0;
    req8 = 8'h01;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("en_off_valid", 32'(valid8), 32'd0);
    end
    en8 = 1'b1;
    tick();
    chk("en_on_valid", 32'(valid8), 32'd1);
    chk("en_on_grant", 32'(grant8), 32'd0);
    en8 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("en_drop_hold", 32'(valid8), 32'd1);
    end
    req8 = '0;
    tick();
    chk("en_drop_rel", 32'(valid8), 32'd0);

    // N=5: grant 4 wraps rr_ptr to 0, so the 1-vs-3 tie goes to 1.
    prt5[4] = 4'd7; prt5[3] = 4'd3; prt5[1] = 4'd3;
    en5 = 1'b1;
    req5 = 5'b11010;
    tick();
    chk("n5_first_grant", 32'(grant5), 32'd4);
    chk("n5_first_oh",    32'(oh5),    32'h10);
    req5[4] = 1'b0;
    tick();
    chk("n5_release", 32'(valid5), 32'd0);
    tick();
    chk("n5_wrap_valid", 32'(valid5), 32'd1);
    chk("n5_wrap_grant", 32'(grant5), 32'd1);
    chk("n5_wrap_oh",    32'(oh5),    32'h02);

    // Tenure limit 3 with requester 3 held: 3 on, 1 off, repeating.
    ent = 1'b1;
    reqt = 8'h08;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("ten_valid", 32'(validt), 32'(pat[c]));
      if (pat[c]) chk("ten_grant", 32'(grantt), 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dyn_prio_arbiter.md
# dyn_prio_arbiter

Parametrised successor to the fixed-width slow arbiter used on the demo board. It grants one of N requesters by per-requester dynamic priority. Ties break round-robin, losers age so they cannot starve, and an optional tenure limit forces release. It sits between the switch/request inputs and the display and grant consumers. An arbitration-enable strobe lets the board top slow decisions to human speed.

## Interface
- N, 8, number of requesters (2..32, need not be a power of two)
- PW, 4, priority width; effective priority saturates at 2^PW-1
- MAX_TEN, 0, maximum grant tenure in cycles; 0 = unlimited
- GW, $clog2(N), grant index width (derived, not overridden)

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  arbitration enable; gates new decisions only
- req  in  N  request vector, bit i = requester i
- prt  in  [PW-1:0] x N (unpacked array)  static priority per requester, larger wins
- valid  out  1  a grant is active
- grant  out  GW  granted index, meaningful while valid=1
- grant_oh  out  N  one-hot of grant, all-zero when valid=0

## Operation
- Two-state FSM: IDLE, GRANT.
- IDLE, with en=1 and |req=1: pick winner, load grant, go GRANT. Otherwise stay.
- Effective priority: eff[i] = min(prt[i] + age[i], 2^PW-1), computed in PW+1 bits. Only requesters with req[i]=1 compete.
- Winner: maximum eff. Ties go to the first tied index at or after rr_ptr, scanning upward and wrapping N-1 -> 0.
- On each decision:
  - rr_ptr <= (winner+1) mod N, with an explicit wrap for non-power-of-two N.
  - age[winner] <= 0.
  - Every other requester with req=1 gets age += 1, saturating at 2^PW-1.
- age[i] clears on any cycle where req[i]=0.
- prt is sampled only on the decision cycle. Changes during GRANT have no effect.
- GRANT: stay while req[grant]=1 and the tenure limit is not reached.
  - Go IDLE when req[grant]=0.
  - Go IDLE when MAX_TEN≠0 and tenure = MAX_TEN-1.
  - en is ignored in GRANT; release proceeds regardless.
- Tenure counter: width $clog2(MAX_TEN+1). Cleared on entry to GRANT. Increments each GRANT cycle.
- Requests from other requesters during GRANT do not preempt.
- Reset: state IDLE, valid=0, grant=0, grant_oh=0, rr_ptr=0, all ages 0, tenure 0. Reset mid-grant drops valid on the next edge.

## Timing
- Decision latency: valid=1 and grant stable starting the cycle after the edge that samples IDLE & en & |req.
- Release latency: valid=0 the cycle after the edge that samples req[grant]=0. Minimum gap between grants is one IDLE cycle.
- Tenure limit: with MAX_TEN=M and req held high, valid is high for exactly M cycles, then low for at least one cycle.
- Outputs are registered. The winner-select logic is combinational from registered age/rr_ptr and live req/prt.
- Simultaneous release and new request: the new request is evaluated in the following IDLE cycle, never the same edge.

## Structure
- Package arb_pkg:
  - enum arb_state_t {IDLE, GRANT}
  - function sat_add(a, b, w)
  - function idx_wrap(i, n)
- Sub-module arb_pick: combinational. Inputs req, eff, rr_ptr. Outputs winner index and any-valid. Reused by future arbiters.
- Top module holds the FSM, age registers, rr_ptr, tenure counter, and the output registers.

## Test plan
- Reset then req=8'h00, en=1 for 10 cycles -> valid=0, grant_oh=0 throughout.
- prt={7,6,5,5,5,5,2,0} (index 7..0), req=8'hFF, en=1, each grant dropped after 2 cycles -> grants 7,6, then 2,3,4,5 round-robin among the tied 5s. Ages lift requesters 1 and 0 within 6 decisions; neither waits forever.
- req=8'b0000_0110, prt all equal, each grant released after 1 cycle -> grants alternate 1,2,1,2. rr_ptr wraps correctly with N=5 (grant 4 -> next scan starts at 0).
- MAX_TEN=3, req[3] held high alone -> valid high 3 cycles, low 1, high 3, repeating.
- Assert rst during GRANT -> next cycle valid=0, grant=0. Next decision uses rr_ptr=0 and ages 0.
- en=0 with req=8'h01 -> no grant. Raise en -> valid=1 one cycle later with grant=0. Dropping en during GRANT does not shorten the grant.
